hps_cmd_bridge: RTL and testbench

//  Avalon-MM slave giving the HPS a parametrised command/response path into the fabric core.
//  - HPS writes into a command window are queued in a FIFO and drained to the core over the wr/wr_busy handshake.
//  - Responses arriving on rd_valid are captured into a readback RAM indexed by response address, and acknowledged on rd.
//  - CSRs provide: core soft reset, FIFO flush, FIFO level, sticky overflow/sampled flags and a capture counter.

---
 rtl/hps_cmd_bridge.sv | 172 +++++++++++++++++
 tb/tb_hps_cmd_bridge.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hps_cmd_bridge.sv
// HPS Avalon-MM command/response bridge: command window queued into a FIFO and drained
// to the core, core responses captured into a readback RAM, plus a small CSR block.
module hps_cmd_bridge #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int WIN_BASE = 100,
  parameter int WIN_SIZE = 200,
  parameter int FIFO_AW  = 4,
  parameter int CAP_BASE = 512,
  parameter int CAP_AW   = 9
) (
  input  logic               s_clk,
  input  logic               s_reset_n,
  input  logic               s_write,
  input  logic               s_read,
  input  logic [ADDR_W-1:0]  s_address,
  input  logic [31:0]        s_writedata,
  output logic [31:0]        s_readdata,
  output logic               main_reset_n,
  output logic               wr,
  input  logic               wr_busy,
  output logic [DATA_W+31:0] wr_instruction,
  input  logic               rd_valid,
  input  logic [DATA_W+31:0] rd_instruction,
  output logic               rd
);

  localparam int DEPTH     = 1 << FIFO_AW;
  localparam int CAP_DEPTH = 1 << CAP_AW;
  localparam int IW        = DATA_W + 32;

  typedef enum logic {D_IDLE, D_ISSUE} drain_t;
  typedef enum logic [1:0] {C_IDLE, C_ACK, C_GAP} cap_t;

  drain_t d_state, d_next;
  cap_t   c_state, c_next;

  logic [31:0] addr_ext;
  logic        sel_ctrl, sel_stat, sel_win, sel_cap;
  logic [CAP_AW-1:0] cap_rd_idx;

  assign addr_ext   = 32'(s_address);
  assign sel_ctrl   = (addr_ext == 32'd0);
  assign sel_stat   = (addr_ext == 32'd1);
  assign sel_win    = (addr_ext >= 32'(WIN_BASE)) && (addr_ext < 32'(WIN_BASE + WIN_SIZE));
  assign sel_cap    = (addr_ext >= 32'(CAP_BASE)) && (addr_ext < 32'(CAP_BASE + CAP_DEPTH));
  assign cap_rd_idx = CAP_AW'(addr_ext - 32'(CAP_BASE));

  logic [IW-1:0]      fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wptr, rptr;
  logic [FIFO_AW:0]   level;
  logic               fifo_empty, fifo_full;
  logic               push_req, push, pop, flush, cap;

  assign fifo_empty = (level == '0);
  assign fifo_full  = level[FIFO_AW];
  assign push_req   = s_write && sel_win;
  // Fullness is judged at the start of the cycle, so a same-cycle pop never rescues a push.
  assign push       = push_req && !fifo_full;
  assign flush      = s_write && sel_ctrl && s_writedata[1];

  always_ff @(posedge s_clk) begin
    if (push) fifo_mem[wptr] <= {DATA_W'(s_writedata), 16'd0, 16'(s_address)};
  end

  always_ff @(posedge s_clk or negedge s_reset_n) begin
    if (!s_reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      rptr  <= wptr;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      level <= level + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    end
  end

  always_ff @(posedge s_clk or negedge s_reset_n) begin
    if (!s_reset_n) begin
      d_state <= D_IDLE;
      c_state <= C_IDLE;
    end else begin
      d_state <= d_next;
      c_state <= c_next;
    end
  end

  always_comb begin
    d_next = d_state;
    pop    = 1'b0;
    case (d_state)
      D_IDLE: if (!fifo_empty && !wr_busy && !flush) begin
        pop    = 1'b1;
        d_next = D_ISSUE;
      end
      D_ISSUE: d_next = D_IDLE;
      default: d_next = D_IDLE;
    endcase
  end

  always_comb begin
    c_next = c_state;
    cap    = 1'b0;
    case (c_state)
      C_IDLE: if (rd_valid) begin
        cap    = 1'b1;
        c_next = C_ACK;
      end
      C_ACK:   c_next = C_GAP;
      C_GAP:   c_next = C_IDLE;
      default: c_next = C_IDLE;
    endcase
  end

  assign wr = (d_state == D_ISSUE);
  assign rd = (c_state == C_ACK);

  always_ff @(posedge s_clk or negedge s_reset_n) begin
    if (!s_reset_n) wr_instruction <= '0;
    else if (pop)   wr_instruction <= fifo_mem[rptr];
  end

  logic [DATA_W-1:0] cap_ram [CAP_DEPTH];
  logic              unused_rd_bits;

  assign unused_rd_bits = &{1'b0, rd_instruction[31:CAP_AW]};

  always_ff @(posedge s_clk) begin
    if (cap) cap_ram[rd_instruction[CAP_AW-1:0]] <= rd_instruction[IW-1:32];
  end

  logic        overflow, sampled;
  logic [15:0] cap_count;
  logic        w1c;

  assign w1c = s_write && sel_stat;

  always_ff @(posedge s_clk or negedge s_reset_n) begin
    if (!s_reset_n) begin
      main_reset_n <= 1'b0;
      overflow     <= 1'b0;
      sampled      <= 1'b0;
      cap_count    <= '0;
    end else begin
      if (s_write && sel_ctrl) main_reset_n <= s_writedata[0];
      if (push_req && fifo_full)        overflow <= 1'b1;
      else if (w1c && s_writedata[2])   overflow <= 1'b0;
      // A capture in the same cycle as a sampled clear keeps the flag set.
      if (cap)                          sampled <= 1'b1;
      else if (w1c && s_writedata[3])   sampled <= 1'b0;
      if (cap && cap_count != 16'hFFFF) cap_count <= cap_count + 16'd1;
    end
  end

  logic [31:0] rd_word;

  always_comb begin
    rd_word = '0;
    if (sel_ctrl)      rd_word = {31'd0, main_reset_n};
    else if (sel_stat) rd_word = {cap_count, 8'(level), 4'd0, sampled, overflow, fifo_full, fifo_empty};
    else if (sel_cap)  rd_word = 32'(cap_ram[cap_rd_idx]);
  end

  always_ff @(posedge s_clk or negedge s_reset_n) begin
    if (!s_reset_n)  s_readdata <= '0;
    else if (s_read) s_readdata <= rd_word;
  end

endmodule

// File: tb/tb_hps_cmd_bridge.sv
// Directed bench for hps_cmd_bridge: CSRs, command drain, response capture, flush and reset abort.
module tb_hps_cmd_bridge;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic               s_clk = 1'b0;
  logic               s_reset_n = 1'b0;
  logic               s_write = 1'b0;
  logic               s_read = 1'b0;
  logic [ADDR_W-1:0]  s_address = '0;
  logic [31:0]        s_writedata = '0;
  logic [31:0]        s_readdata;
  logic               main_reset_n;
  logic               wr;
  logic               wr_busy = 1'b0;
  logic [DATA_W+31:0] wr_instruction;
  logic               rd_valid = 1'b0;
  logic [DATA_W+31:0] rd_instruction = '0;
  logic               rd;

  hps_cmd_bridge dut (
    .s_clk(s_clk), .s_reset_n(s_reset_n), .s_write(s_write), .s_read(s_read),
    .s_address(s_address), .s_writedata(s_writedata), .s_readdata(s_readdata),
    .main_reset_n(main_reset_n), .wr(wr), .wr_busy(wr_busy), .wr_instruction(wr_instruction),
    .rd_valid(rd_valid), .rd_instruction(rd_instruction), .rd(rd)
  );

  always #5 s_clk = ~s_clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [63:0] wr_log[$];
  int          wr_cyc[$];
  int          rd_cyc[$];

  always @(posedge s_clk) cyc++;

  always @(negedge s_clk) begin
    if (wr === 1'b1) begin
      wr_log.push_back(wr_instruction);
      wr_cyc.push_back(cyc);
    end
    if (rd === 1'b1) rd_cyc.push_back(cyc);
  end

  task automatic bus_write(input int addr, input logic [31:0] data);
    @(negedge s_clk);
    s_write = 1'b1; s_address = addr[ADDR_W-1:0]; s_writedata = data;
    @(negedge s_clk);
    s_write = 1'b0;
  endtask

  task automatic bus_read(input int addr, output logic [31:0] data);
    @(negedge s_clk);
    s_read = 1'b1; s_address = addr[ADDR_W-1:0];
    @(negedge s_clk);
    s_read = 1'b0;
    data = s_readdata;
  endtask

  task automatic clear_logs();
    wr_log.delete(); wr_cyc.delete(); rd_cyc.delete();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (3) @(negedge s_clk);
    s_reset_n = 1'b1;
    @(negedge s_clk);
    n_cmp++;
    if ({wr, rd, main_reset_n} !== 3'b000) begin
      n_err++; $display("FAIL reset_outputs: got wr/rd/main=%b expected 000", {wr, rd, main_reset_n});
    end
    n_cmp++;
    if (wr_instruction !== 64'd0 || s_readdata !== 32'd0) begin
      n_err++; $display("FAIL reset_data: got instr=%h readdata=%h expected 0/0", wr_instruction, s_readdata);
    end
    bus_read(0, d);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL reset_ctrl: got %h expected 00000000", d); end
    bus_read(1, d);
    n_cmp++;
    if (d !== 32'h1) begin n_err++; $display("FAIL reset_status: got %h expected 00000001", d); end
    bus_write(0, 32'h1);
    n_cmp++;
    if (main_reset_n !== 1'b1) begin n_err++; $display("FAIL ctrl_main_reset: got %b expected 1", main_reset_n); end
  endtask

  task automatic test_single_cmd();
    logic [31:0] d;
    clear_logs();
    bus_write(150, 32'hDEADBEEF);
    repeat (6) @(negedge s_clk);
    n_cmp++;
    if (wr_log.size() !== 1) begin
      n_err++; $display("FAIL single_pulse_count: got %0d expected 1", wr_log.size());
    end else begin
      n_cmp++;
      if (wr_log[0] !== 64'hDEADBEEF_0000_0096) begin
        n_err++; $display("FAIL single_instr: got %h expected deadbeef00000096", wr_log[0]);
      end
    end
    bus_read(1, d);
    n_cmp++;
    if (d !== 32'h1) begin n_err++; $display("FAIL single_level: got %h expected 00000001", d); end
  endtask

  task automatic test_fill_overflow_drain();
    logic [31:0] d;
    logic [63:0] exp;
    wr_busy = 1'b1;
    for (int i = 0; i < 17; i++) bus_write(100 + i, 32'h1000 + i);
    bus_read(1, d);
    n_cmp++;
    if (d !== 32'h0000_1006) begin n_err++; $display("FAIL full_status: got %h expected 00001006", d); end
    clear_logs();
    @(negedge s_clk);
    wr_busy = 1'b0;
    repeat (40) @(negedge s_clk);
    n_cmp++;
    if (wr_log.size() !== 16) begin
      n_err++; $display("FAIL drain_count: got %0d expected 16", wr_log.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        exp = {32'h1000 + 32'(i), 16'd0, 16'(100 + i)};
        n_cmp++;
        if (wr_log[i] !== exp) begin
          n_err++; $display("FAIL drain_instr[%0d]: got %h expected %h", i, wr_log[i], exp);
        end
        if (i > 0) begin
          n_cmp++;
          if (wr_cyc[i] - wr_cyc[i-1] !== 2) begin
            n_err++; $display("FAIL drain_spacing[%0d]: got %0d expected 2", i, wr_cyc[i] - wr_cyc[i-1]);
          end
        end
      end
    end
    bus_read(1, d);
    n_cmp++;
    if (d !== 32'h0000_0005) begin n_err++; $display("FAIL drained_status: got %h expected 00000005", d); end
  endtask

  task automatic test_capture();
    logic [31:0] d;
    clear_logs();
    @(negedge s_clk);
    rd_valid = 1'b1; rd_instruction = 64'h12345678_0000_0205;
    repeat (9) @(negedge s_clk);
    rd_valid = 1'b0;
    repeat (4) @(negedge s_clk);
    n_cmp++;
    if (rd_cyc.size() !== 3) begin
      n_err++; $display("FAIL capture_pulses: got %0d expected 3", rd_cyc.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        n_cmp++;
        if (rd_cyc[i] - rd_cyc[i-1] !== 3) begin
          n_err++; $display("FAIL capture_spacing[%0d]: got %0d expected 3", i, rd_cyc[i] - rd_cyc[i-1]);
        end
      end
    end
    bus_read(517, d);
    n_cmp++;
    if (d !== 32'h12345678) begin n_err++; $display("FAIL ram_5: got %h expected 12345678", d); end
    @(negedge s_clk);
    rd_valid = 1'b1; rd_instruction = 64'hCAFEF00D_0000_03FF;
    @(negedge s_clk);
    rd_valid = 1'b0;
    repeat (3) @(negedge s_clk);
    bus_read(1023, d);
    n_cmp++;
    if (d !== 32'hCAFEF00D) begin n_err++; $display("FAIL ram_wrap_511: got %h expected cafef00d", d); end
    bus_read(517, d);
    n_cmp++;
    if (d !== 32'h12345678) begin n_err++; $display("FAIL ram_5_kept: got %h expected 12345678", d); end
    bus_read(1, d);
    n_cmp++;
    if (d !== 32'h0004_000D) begin n_err++; $display("FAIL capture_status: got %h expected 0004000d", d); end
    bus_read(50, d);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL unmapped_read: got %h expected 00000000", d); end
    bus_read(120, d);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL window_read: got %h expected 00000000", d); end
  endtask

  task automatic test_w1c_flush();
    logic [31:0] d;
    bus_write(1, 32'h0C);
    bus_read(1, d);
    n_cmp++;
    if (d !== 32'h0004_0001) begin n_err++; $display("FAIL w1c_status: got %h expected 00040001", d); end
    wr_busy = 1'b1;
    for (int i = 0; i < 5; i++) bus_write(200 + i, 32'hA0 + i);
    bus_read(1, d);
    n_cmp++;
    if (d !== 32'h0004_0500) begin n_err++; $display("FAIL level5_status: got %h expected 00040500", d); end
    clear_logs();
    bus_write(0, 32'h3);
    bus_read(1, d);
    n_cmp++;
    if (d !== 32'h0004_0001) begin n_err++; $display("FAIL flush_status: got %h expected 00040001", d); end
    bus_read(0, d);
    n_cmp++;
    if (d !== 32'h1) begin n_err++; $display("FAIL flush_ctrl_readback: got %h expected 00000001", d); end
    wr_busy = 1'b0;
    repeat (6) @(negedge s_clk);
    n_cmp++;
    if (wr_log.size() !== 0) begin n_err++; $display("FAIL flush_no_issue: got %0d pulses expected 0", wr_log.size()); end
    bus_write(0, 32'h0);
    n_cmp++;
    if (main_reset_n !== 1'b0) begin n_err++; $display("FAIL soft_reset_out: got %b expected 0", main_reset_n); end
    @(negedge s_clk);
    s_write = 1'b1; s_address = 10'd1; s_writedata = 32'h8;
    rd_valid = 1'b1; rd_instruction = 64'hA5A5A5A5_0000_0010;
    @(negedge s_clk);
    s_write = 1'b0; rd_valid = 1'b0;
    repeat (3) @(negedge s_clk);
    bus_read(1, d);
    n_cmp++;
    if (d !== 32'h0005_0009) begin n_err++; $display("FAIL capture_beats_w1c: got %h expected 00050009", d); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] d;
    int k;
    wr_busy = 1'b1;
    for (int i = 0; i < 3; i++) bus_write(110 + i, 32'h55 + i);
    @(negedge s_clk);
    wr_busy = 1'b0;
    k = 0;
    while (wr !== 1'b1 && k < 8) begin @(negedge s_clk); k++; end
    n_cmp++;
    if (wr !== 1'b1) begin n_err++; $display("FAIL wait_issue: got wr=%b expected 1 within 8 cycles", wr); end
    s_reset_n = 1'b0;
    #1;
    n_cmp++;
    if (wr !== 1'b0 || wr_instruction !== 64'd0) begin
      n_err++; $display("FAIL abort_issue: got wr=%b instr=%h expected 0/0", wr, wr_instruction);
    end
    @(negedge s_clk);
    s_reset_n = 1'b1;
    rd_valid = 1'b1; rd_instruction = 64'h0BADF00D_0000_0001;
    k = 0;
    while (rd !== 1'b1 && k < 8) begin @(negedge s_clk); k++; end
    n_cmp++;
    if (rd !== 1'b1) begin n_err++; $display("FAIL wait_ack: got rd=%b expected 1 within 8 cycles", rd); end
    rd_valid = 1'b0;
    s_reset_n = 1'b0;
    #1;
    n_cmp++;
    if (rd !== 1'b0 || main_reset_n !== 1'b0 || s_readdata !== 32'd0) begin
      n_err++; $display("FAIL abort_ack: got rd=%b main=%b readdata=%h expected 0/0/0", rd, main_reset_n, s_readdata);
    end
    @(negedge s_clk);
    s_reset_n = 1'b1;
    clear_logs();
    repeat (6) @(negedge s_clk);
    n_cmp++;
    if (wr_log.size() !== 0) begin n_err++; $display("FAIL reset_fifo_empty: got %0d pulses expected 0", wr_log.size()); end
    bus_read(1, d);
    n_cmp++;
    if (d !== 32'h1) begin n_err++; $display("FAIL post_reset_status: got %h expected 00000001", d); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_cmd();
    test_fill_overflow_drain();
    test_capture();
    test_w1c_flush();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
